lsu_align: RTL and testbench
============================

# lsu_align

Load/store alignment unit between the core's execute stage and the word-organised `data_memory`. It accepts RV32 byte-addressed load/store requests and converts them to word address, byte enables and lane-shifted write data. It extracts and sign/zero-extends load data and returns a registered response. Misaligned accesses are split into two memory beats by a small FSM.

## Interface
- `ADDR_WIDTH`, 15, word-address width of `data_memory`; byte space is 2^(ADDR_WIDTH+2).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: core presents a load/store.
- `req_ready` out 1: request accepted when `req_valid & req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV funct3. Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. Stores: 000 sb, 001 sh, 010 sw.
- `req_addr` in 32: byte address; bits above ADDR_WIDTH+1 ignored.
- `req_wdata` in 32: store data, right-justified.
- `resp_valid` out 1: one-cycle pulse, one per accepted request.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: qualified by `resp_valid`.
- `mem_we` out 1, `mem_be` out 4, `mem_addr` out ADDR_WIDTH, `mem_wdata` out 32: to `data_memory`.
- `mem_op_read` out 3: constant 3'b010 (raw word); all extension is done here.
- `mem_rdata` in 32: combinational read data for `mem_addr`.

## Operation
- **Size:** 1, 2 or 4 bytes from funct3[1:0]. Offset `off` = addr[1:0]. Word address `wa` = addr[ADDR_WIDTH+1:2].
- **Byte mask:** the size mask (0001/0011/1111) is shifted left by `off` into 8 bits. Low nibble is beat 1; high nibble is beat 2.
- **Write data:** `req_wdata` is shifted left by 8·`off` into 64 bits. Low word goes to beat 1, high word to beat 2.
- **Aligned request** (high nibble zero): a single beat at `wa`, driven combinationally from request inputs in the accept cycle.
- **Misaligned request** (high nibble non-zero):
  - Beat 1 at `wa` in the accept cycle.
  - Beat 2 at (`wa`+1) mod 2^ADDR_WIDTH in the next cycle, from registered state.
  - For loads, beat-1 `mem_rdata` is captured. The result is bytes [off+size-1 : off] of {beat2, beat1}.
- **Load result:** sign-extended for 000/001/010, zero-extended for 100/101.
- **Illegal funct3** (loads 011/110/111; stores any except 000/001/010): no memory write (`mem_we`=0), single-beat timing, `resp_err`=1, `resp_rdata`=0.
- **Idle outputs:** `mem_we`=0 and `mem_be`=0 whenever no beat is issued.
- **FSM:**
  - IDLE → BEAT2 on accepting a misaligned request; otherwise stays in IDLE.
  - BEAT2 → IDLE unconditionally.
  - `req_ready` = (state==IDLE).
- **Reset values:** state IDLE, `resp_valid` 0, `resp_rdata` 0, `resp_err` 0, captured word 0. `mem_we` is forced 0 while `rst_n` is low.
- **Reset in BEAT2:** beat 2 is abandoned and no response is issued. A beat-1 store write already performed stays in memory.

## Timing
- **Aligned / error:** accept in cycle N, memory access in N, `resp_valid` in N+1. `req_ready` stays high, so throughput is 1/cycle.
- **Misaligned:** accept in N (beat 1), beat 2 in N+1 with `req_ready`=0, `resp_valid` in N+2. A new request may be accepted in N+2.
- **Response registers:** `resp_*` are registered and update only with `resp_valid`; they hold their value otherwise.
- **Memory path:** a store write lands at the rising edge ending its beat cycle. A load in the next cycle sees the new data (no forwarding needed).

## Configuration
- Macro `LSU_MISALIGN_EN`.
- **Defined:** misaligned accesses are split as above.
- **Undefined:**
  - BEAT2 does not exist and `req_ready` is tied to 1.
  - A misaligned request performs no write and returns `resp_err`=1, `resp_rdata`=0, with single-beat timing.
  - Aligned behaviour is identical in both builds.

## Structure
- **Package `lsu_pkg`:** funct3 encodings as localparams, FSM state enum, and `MEM_OP_RAW` = 3'b010.
- **Sub-module `lsu_extract`:** combinational. Takes {hi, lo} words, `off` and funct3; produces the extended 32-bit result. Instantiated once.

## Test plan
- Word 0x80 = 0x80FF7F01; lb at 0x203 in N → `resp_valid` N+1, `resp_rdata` 0xFFFFFF80, `resp_err` 0.
- Same word; lhu at 0x202 → 0x000080FF. Then lw 0x200 back-to-back in N+1 → 0x80FF7F01 in N+2.
- Misaligned store (macro on): sw 0x11223344 at 0x101.
  - Beat 1: word 0x40, be 1110, wdata 0x22334400.
  - Beat 2: word 0x41, be 0001, wdata 0x00000011.
  - `req_ready` 0 in N+1; `resp_valid` in N+2.
  - Follow-up lw 0x101 → 0x11223344.
- Wrap-around (macro on, ADDR_WIDTH=15):
  - Setup: word 0x7FFF = 0xAABBCCDD, word 0x0000 = 0x00001122.
  - lw at 0x1FFFE → beat-2 address 0x0000, result 0x1122AABB.
- Macro off: lh at 0x003 → `mem_we` 0, `resp_err` 1, `resp_rdata` 0 in N+1. Store with funct3 011 → no write, `resp_err` 1.
- Reset mid-access: assert `rst_n`=0 during BEAT2 of a misaligned store.
  - `req_ready` goes to 1 and `resp_valid` to 0 asynchronously.
  - Beat-2 word stays unchanged.

Source files
------------

// File: rtl/lsu_pkg.sv
// Purpose: shared encodings for the load/store alignment unit (funct3 codes,
//          FSM states, memory read-op code) plus small decode helpers.
// Ports:   none (package).
package lsu_pkg;

    // RV32 funct3 encodings for loads/stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // data_memory read-op: raw word; all extension happens in lsu_extract
    localparam logic [2:0] MEM_OP_RAW = 3'b010;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BEAT2 = 1'b1
    } lsu_state_e;

    // Byte-lane mask of an access before shifting by the address offset.
    // Illegal size code 2'b11 yields an empty mask so it never looks misaligned.
    function automatic logic [3:0] size_mask(input logic [2:0] funct3);
        logic [3:0] m;
        case (funct3[1:0])
            2'b00:   m = 4'b0001;
            2'b01:   m = 4'b0011;
            2'b10:   m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
        logic ok;
        if (we) begin
            ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end else begin
            ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                 (funct3 == F3_BU) || (funct3 == F3_HU);
        end
        return ok;
    endfunction

endpackage

// File: rtl/lsu_extract.sv
// Purpose: select the addressed bytes out of a two-word window and sign/zero extend.
// Ports:   hi/lo = upper/lower memory words, off = byte offset into lo,
//          funct3 = load type, result = extended value (0 for non-load codes).
module lsu_extract
    import lsu_pkg::*;
(
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] sel;

    always_comb begin
        // Shift the 64-bit window right so the first addressed byte lands in lane 0
        sel    = 32'({hi, lo} >> {off, 3'b000});
        result = 32'h0;
        case (funct3)
            F3_B:    result = {{24{sel[7]}}, sel[7:0]};
            F3_H:    result = {{16{sel[15]}}, sel[15:0]};
            F3_W:    result = sel;
            F3_BU:   result = {24'h0, sel[7:0]};
            F3_HU:   result = {16'h0, sel[15:0]};
            default: result = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_align.sv
// Purpose: convert RV32 byte-addressed load/store requests into word-memory beats
//          (address, byte enables, lane-shifted data) and return extended load data.
//          Misaligned accesses are split into two beats when LSU_MISALIGN_EN is
//          defined; otherwise they are rejected with resp_err.
// Ports:   req_* = core request (valid/ready), resp_* = registered one-cycle response,
//          mem_* = combinational interface to data_memory (mem_rdata same-cycle).
// Latency: aligned/error 1 cycle to resp_valid; misaligned 2 cycles, req_ready low
//          during the second beat.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [2:0]            mem_op_read,
    input  logic [31:0]           mem_rdata
);

    // ---------------- request decode ----------------
    logic [1:0]            off;
    logic [ADDR_WIDTH-1:0] wa;
    logic [7:0]            mask8;
    logic [63:0]           wdata64;
    logic                  legal;
    logic                  split;
    logic                  accept;

    assign off     = req_addr[1:0];
    assign wa      = req_addr[ADDR_WIDTH+1:2];
    assign mask8   = {4'b0000, size_mask(req_funct3)} << off;
    assign wdata64 = {32'h0, req_wdata} << {off, 3'b000};
    assign legal   = funct3_legal(req_we, req_funct3);
    // Any lane pushed into the upper nibble means the access crosses a word
    assign split   = |mask8[7:4];
    assign accept  = req_valid & req_ready;

    // Byte address bits above the memory's reach are deliberately ignored
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

    assign mem_op_read = MEM_OP_RAW;

    // ---------------- response registers ----------------
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q,   resp_err_d;

    // ---------------- extraction ----------------
    logic [31:0] ext_hi, ext_lo, ext_result;
    logic [1:0]  ext_off;
    logic [2:0]  ext_f3;

    lsu_extract u_extract (
        .hi     (ext_hi),
        .lo     (ext_lo),
        .off    (ext_off),
        .funct3 (ext_f3),
        .result (ext_result)
    );

    logic mem_we_c;
    // A beat must never write while reset is held, regardless of stale state
    assign mem_we = mem_we_c & rst_n;

`ifdef LSU_MISALIGN_EN
    // ---------------- second-beat state ----------------
    lsu_state_e            state_q,   state_d;
    logic [31:0]           cap_q,     cap_d;      // beat-1 read word
    logic                  b2_we_q,   b2_we_d;
    logic [3:0]            b2_be_q,   b2_be_d;
    logic [ADDR_WIDTH-1:0] b2_addr_q, b2_addr_d;
    logic [31:0]           b2_wdata_q, b2_wdata_d;
    logic [1:0]            b2_off_q,  b2_off_d;
    logic [2:0]            b2_f3_q,   b2_f3_d;

    assign req_ready = (state_q == ST_IDLE);
`else
    assign req_ready = 1'b1;

    // Upper write lanes only feed a second beat, which this build never issues
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^wdata64[63:32];
`endif

    always_comb begin
        mem_we_c     = 1'b0;
        mem_be       = 4'b0000;
        mem_addr     = wa;
        mem_wdata    = wdata64[31:0];
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        ext_hi       = 32'h0;
        ext_lo       = mem_rdata;
        ext_off      = off;
        ext_f3       = req_funct3;
`ifdef LSU_MISALIGN_EN
        state_d    = state_q;
        cap_d      = cap_q;
        b2_we_d    = b2_we_q;
        b2_be_d    = b2_be_q;
        b2_addr_d  = b2_addr_q;
        b2_wdata_d = b2_wdata_q;
        b2_off_d   = b2_off_q;
        b2_f3_d    = b2_f3_q;

        if (state_q == ST_BEAT2) begin
            // Second beat: drive from registered state, finish the response
            mem_we_c     = b2_we_q;
            mem_be       = b2_be_q;
            mem_addr     = b2_addr_q;
            mem_wdata    = b2_wdata_q;
            ext_hi       = mem_rdata;
            ext_lo       = cap_q;
            ext_off      = b2_off_q;
            ext_f3       = b2_f3_q;
            resp_valid_d = 1'b1;
            resp_rdata_d = b2_we_q ? 32'h0 : ext_result;
            resp_err_d   = 1'b0;
            state_d      = ST_IDLE;
        end else
`endif
        if (accept) begin
`ifdef LSU_MISALIGN_EN
            if (!legal) begin
`else
            if (!legal || split) begin
`endif
                // Rejected: no beat issued, single-cycle error response
                resp_valid_d = 1'b1;
                resp_rdata_d = 32'h0;
                resp_err_d   = 1'b1;
            end else begin
                mem_we_c = req_we;
                mem_be   = mask8[3:0];
`ifdef LSU_MISALIGN_EN
                if (split) begin
                    state_d    = ST_BEAT2;
                    cap_d      = mem_rdata;
                    b2_we_d    = req_we;
                    b2_be_d    = mask8[7:4];
                    b2_addr_d  = wa + ADDR_WIDTH'(1);   // wraps at top of memory
                    b2_wdata_d = wdata64[63:32];
                    b2_off_d   = off;
                    b2_f3_d    = req_funct3;
                end else
`endif
                begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = req_we ? 32'h0 : ext_result;
                    resp_err_d   = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

`ifdef LSU_MISALIGN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cap_q      <= 32'h0;
            b2_we_q    <= 1'b0;
            b2_be_q    <= 4'b0000;
            b2_addr_q  <= '0;
            b2_wdata_q <= 32'h0;
            b2_off_q   <= 2'b00;
            b2_f3_q    <= 3'b000;
        end else begin
            state_q    <= state_d;
            cap_q      <= cap_d;
            b2_we_q    <= b2_we_d;
            b2_be_q    <= b2_be_d;
            b2_addr_q  <= b2_addr_d;
            b2_wdata_q <= b2_wdata_d;
            b2_off_q   <= b2_off_d;
            b2_f3_q    <= b2_f3_d;
        end
    end
`endif

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_align.sv
// Purpose: self-checking bench for lsu_align with a word-organised memory model.
// Latency: n/a (bench).
// Backpressure: requests issued only while req_ready is high.
module tb_lsu_align;

    localparam int AW = 15;

    logic          clk;
    logic          rst_n;
    logic          req_valid, req_ready, req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr, req_wdata;
    logic          resp_valid, resp_err;
    logic [31:0]   resp_rdata;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic [2:0]    mem_op_read;

    lsu_align #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_op_read(mem_op_read), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    logic [31:0]   tmem [0:(1<<AW)-1];
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [31:0]   bd_dat;

    always @(posedge clk) begin
        if (bd_we) tmem[bd_addr] <= bd_dat;
        else if (mem_we)
            for (int i = 0; i < 4; i++)
                if (mem_be[i]) tmem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
    assign mem_rdata = tmem[mem_addr];

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bd_write(input logic [AW-1:0] a, input logic [31:0] d);
        bd_addr = a; bd_dat = d; bd_we = 1'b1;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    // Called at posedge+1 with req_ready high; returns response and latency.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er,
                          output int lat, output logic we_seen);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        #1;
        we_seen = mem_we;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 6) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = resp_rdata;
        er = resp_err;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd,
                       input logic exp_err, input int exp_lat);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wd = wd;
        v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_lat = exp_lat;
        vecs.push_back(v);
    endtask

    logic [31:0] rd;
    logic        er, ws;
    int          lat;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0; bd_we = 1'b0; bd_addr = '0; bd_dat = 32'h0;

        // Aligned vectors, identical in both builds
        add(0, 3'b000, 32'h203, 0, 32'hFFFFFF80, 0, 1);
        add(0, 3'b101, 32'h202, 0, 32'h000080FF, 0, 1);
        add(0, 3'b010, 32'h200, 0, 32'h80FF7F01, 0, 1);
        add(0, 3'b100, 32'h200, 0, 32'h00000001, 0, 1);
        add(0, 3'b000, 32'h201, 0, 32'h0000007F, 0, 1);
        add(0, 3'b001, 32'h200, 0, 32'h00007F01, 0, 1);
        add(0, 3'b100, 32'h202, 0, 32'h000000FF, 0, 1);
        add(0, 3'b001, 32'h202, 0, 32'hFFFF80FF, 0, 1);
        add(0, 3'b011, 32'h200, 0, 32'h0, 1, 1);
        add(0, 3'b110, 32'h200, 0, 32'h0, 1, 1);
        add(0, 3'b111, 32'h200, 0, 32'h0, 1, 1);
        add(1, 3'b011, 32'h204, 32'hDEADBEEF, 32'h0, 1, 1);
        add(1, 3'b100, 32'h204, 32'hDEADBEEF, 32'h0, 1, 1);
        add(0, 3'b010, 32'h204, 0, 32'h55555555, 0, 1);
        add(1, 3'b000, 32'h205, 32'hFFFFFFAB, 32'h0, 0, 1);
        add(0, 3'b010, 32'h204, 0, 32'h5555AB55, 0, 1);
        add(1, 3'b001, 32'h206, 32'hFFFF1234, 32'h0, 0, 1);
        add(0, 3'b010, 32'h204, 0, 32'h1234AB55, 0, 1);
        add(0, 3'b000, 32'h206, 0, 32'h00000034, 0, 1);
        add(1, 3'b010, 32'h208, 32'hCAFEF00D, 32'h0, 0, 1);
        add(0, 3'b010, 32'h208, 0, 32'hCAFEF00D, 0, 1);
        add(0, 3'b001, 32'h20A, 0, 32'hFFFFCAFE, 0, 1);
`ifdef LSU_MISALIGN_EN
        add(0, 3'b010, 32'h1FFFE, 0, 32'h1122AABB, 0, 2);
        add(0, 3'b001, 32'h203, 0, 32'h00005580, 0, 2);
        add(0, 3'b101, 32'h1FFFF, 0, 32'h000022AA, 0, 2);
        add(0, 3'b010, 32'h206, 0, 32'hF00D1234, 0, 2);
        add(1, 3'b001, 32'h207, 32'h0000BEEF, 32'h0, 0, 2);
        add(0, 3'b010, 32'h206, 0, 32'hF0BEEF34, 0, 2);
        add(0, 3'b010, 32'h204, 0, 32'hEF34AB55, 0, 1);
`else
        add(0, 3'b001, 32'h003, 0, 32'h0, 1, 1);
        add(0, 3'b010, 32'h1FFFE, 0, 32'h0, 1, 1);
        add(1, 3'b010, 32'h209, 32'h12345678, 32'h0, 1, 1);
        add(0, 3'b010, 32'h208, 0, 32'hCAFEF00D, 0, 1);
`endif

        // Preload memory while reset holds the DUT quiet
        @(posedge clk); #1;
        bd_write(15'h0080, 32'h80FF7F01);
        bd_write(15'h0081, 32'h55555555);
        bd_write(15'h7FFF, 32'hAABBCCDD);
        bd_write(15'h0000, 32'h00001122);
        bd_write(15'h0040, 32'h00000000);
        bd_write(15'h0041, 32'h00000000);
        bd_write(15'h0060, 32'h00000000);
        bd_write(15'h0061, 32'h77777777);

        // Reset state
        chk("rst req_ready", 32'(req_ready), 32'h1);
        chk("rst resp_valid", 32'(resp_valid), 32'h0);
        chk("rst resp_rdata", resp_rdata, 32'h0);
        chk("rst resp_err", 32'(resp_err), 32'h0);
        chk("rst mem_we", 32'(mem_we), 32'h0);

        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        chk("idle mem_we", 32'(mem_we), 32'h0);
        chk("idle mem_be", 32'(mem_be), 32'h0);
        chk("mem_op_read", 32'(mem_op_read), 32'h2);

        // Table-driven vectors
        foreach (vecs[i]) begin
            do_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wd, rd, er, lat, ws);
            chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d err", i), 32'(er), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            if (vecs[i].we)
                chk($sformatf("vec%0d mem_we", i), 32'(ws), 32'(!vecs[i].exp_err));
        end

        // Back-to-back aligned loads, then response hold
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b101; req_addr = 32'h202;
        @(posedge clk); #1;
        chk("b2b first valid", 32'(resp_valid), 32'h1);
        chk("b2b first rdata", resp_rdata, 32'h000080FF);
        chk("b2b ready", 32'(req_ready), 32'h1);
        req_funct3 = 3'b010; req_addr = 32'h200;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("b2b second valid", 32'(resp_valid), 32'h1);
        chk("b2b second rdata", resp_rdata, 32'h80FF7F01);
        @(posedge clk); #1;
        chk("hold valid low", 32'(resp_valid), 32'h0);
        chk("hold rdata", resp_rdata, 32'h80FF7F01);

`ifdef LSU_MISALIGN_EN
        // Misaligned store split into two beats
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h101; req_wdata = 32'h11223344;
        #1;
        chk("ms b1 we", 32'(mem_we), 32'h1);
        chk("ms b1 addr", 32'(mem_addr), 32'h40);
        chk("ms b1 be", 32'(mem_be), 32'hE);
        chk("ms b1 wdata", mem_wdata, 32'h22334400);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("ms b2 ready", 32'(req_ready), 32'h0);
        chk("ms b2 valid", 32'(resp_valid), 32'h0);
        chk("ms b2 we", 32'(mem_we), 32'h1);
        chk("ms b2 addr", 32'(mem_addr), 32'h41);
        chk("ms b2 be", 32'(mem_be), 32'h1);
        chk("ms b2 wdata", mem_wdata, 32'h00000011);
        @(posedge clk); #1;
        chk("ms resp valid", 32'(resp_valid), 32'h1);
        chk("ms resp err", 32'(resp_err), 32'h0);
        chk("ms ready back", 32'(req_ready), 32'h1);
        chk("ms word40", tmem[15'h40], 32'h22334400);
        chk("ms word41", tmem[15'h41], 32'h00000011);
        do_req(0, 3'b010, 32'h101, 0, rd, er, lat, ws);
        chk("ms reload rdata", rd, 32'h11223344);
        chk("ms reload latency", 32'(lat), 32'h2);

        // Reset asserted during BEAT2 of a misaligned store
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h183; req_wdata = 32'hAABBCCDD;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rb in beat2", 32'(req_ready), 32'h0);
        #1 rst_n = 1'b0;
        #1;
        chk("rb ready async", 32'(req_ready), 32'h1);
        chk("rb valid async", 32'(resp_valid), 32'h0);
        chk("rb mem_we", 32'(mem_we), 32'h0);
        @(posedge clk); #1;
        chk("rb word61 kept", tmem[15'h61], 32'h77777777);
        chk("rb word60 beat1", tmem[15'h60], 32'hDD000000);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rb no resp", 32'(resp_valid), 32'h0);
`else
        // Misaligned store rejected without touching memory
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h101; req_wdata = 32'h11223344;
        #1;
        chk("mo we", 32'(mem_we), 32'h0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("mo resp valid", 32'(resp_valid), 32'h1);
        chk("mo resp err", 32'(resp_err), 32'h1);
        chk("mo ready", 32'(req_ready), 32'h1);
        chk("mo word40", tmem[15'h40], 32'h0);
        chk("mo word41", tmem[15'h41], 32'h0);
`endif

        // Reset clears a pending response asynchronously
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h200;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("ra valid before", 32'(resp_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("ra valid cleared", 32'(resp_valid), 32'h0);
        chk("ra rdata cleared", resp_rdata, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
